// File: rtl/ew_fifo_s1_sf_if.sv
// rtl/ew_fifo_s1_sf_if.sv - push/pop request, data and status flag bundle for ew_fifo_s1_sf
interface ew_fifo_s1_sf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  push_req_n;
    logic                  pop_req_n;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  push_empty;
    logic                  push_ae;
    logic                  push_hf;
    logic                  push_af;
    logic                  push_full;
    logic                  push_error;
    logic                  pop_empty;
    logic                  pop_ae;
    logic                  pop_hf;
    logic                  pop_af;
    logic                  pop_full;
    logic                  pop_error;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output push_req_n, pop_req_n, data_in,
        input  push_empty, push_ae, push_hf, push_af, push_full, push_error,
        input  pop_empty, pop_ae, pop_hf, pop_af, pop_full, pop_error,
        input  data_out
    );

    modport slave (
        input  push_req_n, pop_req_n, data_in,
        output push_empty, push_ae, push_hf, push_af, push_full, push_error,
        output pop_empty, pop_ae, pop_hf, pop_af, pop_full, pop_error,
        output data_out
    );
endinterface

// File: rtl/ew_fifo_s1_sf.sv
// rtl/ew_fifo_s1_sf.sv - single-clock FIFO with delayed cross-side visibility and per-side status flags
module ew_fifo_s1_sf #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 8,
    parameter int WR_AE_LVL  = 2,
    parameter int WR_AF_LVL  = 2,
    parameter int RD_AE_LVL  = 2,
    parameter int RD_AF_LVL  = 2,
    parameter int ERR_MODE   = 0,
    parameter int WR_SYNC    = 2,
    parameter int RD_SYNC    = 2
) (
    input  logic           clk,
    input  logic           rst,
    ew_fifo_s1_sf_if.slave bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_C  = PW'(RAM_DEPTH);
    localparam logic [PW-1:0] HALF_C   = PW'(RAM_DEPTH / 2);
    localparam logic [PW-1:0] WR_AE_C  = PW'(WR_AE_LVL);
    localparam logic [PW-1:0] WR_AF_C  = PW'(RAM_DEPTH - WR_AF_LVL);
    localparam logic [PW-1:0] RD_AE_C  = PW'(RD_AE_LVL);
    localparam logic [PW-1:0] RD_AF_C  = PW'(RAM_DEPTH - RD_AF_LVL);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] rd_dly     [1:WR_SYNC];
    logic [PW-1:0] rd_dly_nxt [1:WR_SYNC];
    logic [PW-1:0] wr_dly     [1:RD_SYNC];
    logic [PW-1:0] wr_dly_nxt [1:RD_SYNC];
    logic [PW-1:0] push_cnt_nxt;
    logic [PW-1:0] pop_cnt_nxt;

    logic push_acc;
    logic push_ovf;
    logic pop_acc;
    logic pop_unf;

    logic push_empty_q, push_ae_q, push_hf_q, push_af_q, push_full_q, push_err_q;
    logic pop_empty_q, pop_ae_q, pop_hf_q, pop_af_q, pop_full_q, pop_err_q;

    // Each side judges acceptance only from its own registered flags.
    always_comb begin
        push_acc   = !bus.push_req_n && !push_full_q;
        push_ovf   = !bus.push_req_n &&  push_full_q;
        pop_acc    = !bus.pop_req_n  && !pop_empty_q;
        pop_unf    = !bus.pop_req_n  &&  pop_empty_q;
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_acc};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop_acc};

        rd_dly_nxt[1] = rd_ptr;
        for (int i = 2; i <= WR_SYNC; i++) begin
            rd_dly_nxt[i] = rd_dly[i-1];
        end
        wr_dly_nxt[1] = wr_ptr;
        for (int i = 2; i <= RD_SYNC; i++) begin
            wr_dly_nxt[i] = wr_dly[i-1];
        end

        push_cnt_nxt = wr_ptr_nxt - rd_dly_nxt[WR_SYNC];
        pop_cnt_nxt  = wr_dly_nxt[RD_SYNC] - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 1; i <= WR_SYNC; i++) rd_dly[i] <= '0;
            for (int i = 1; i <= RD_SYNC; i++) wr_dly[i] <= '0;
            push_empty_q <= 1'b1;
            push_ae_q    <= 1'b1;
            push_hf_q    <= 1'b0;
            push_af_q    <= 1'b0;
            push_full_q  <= 1'b0;
            push_err_q   <= 1'b0;
            pop_empty_q  <= 1'b1;
            pop_ae_q     <= 1'b1;
            pop_hf_q     <= 1'b0;
            pop_af_q     <= 1'b0;
            pop_full_q   <= 1'b0;
            pop_err_q    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            rd_dly <= rd_dly_nxt;
            wr_dly <= wr_dly_nxt;

            push_empty_q <= (push_cnt_nxt == '0);
            push_ae_q    <= (push_cnt_nxt <= WR_AE_C);
            push_hf_q    <= (push_cnt_nxt >= HALF_C);
            push_af_q    <= (push_cnt_nxt >= WR_AF_C);
            push_full_q  <= (push_cnt_nxt == DEPTH_C);

            pop_empty_q  <= (pop_cnt_nxt == '0);
            pop_ae_q     <= (pop_cnt_nxt <= RD_AE_C);
            pop_hf_q     <= (pop_cnt_nxt >= HALF_C);
            pop_af_q     <= (pop_cnt_nxt >= RD_AF_C);
            pop_full_q   <= (pop_cnt_nxt == DEPTH_C);

            push_err_q <= (ERR_MODE == 0) ? (push_err_q | push_ovf) : push_ovf;
            pop_err_q  <= (ERR_MODE == 0) ? (pop_err_q  | pop_unf)  : pop_unf;
        end
    end

    // Storage is never reset; a reset only discards it by clearing the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem[wr_ptr[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.push_empty = push_empty_q;
    assign bus.push_ae    = push_ae_q;
    assign bus.push_hf    = push_hf_q;
    assign bus.push_af    = push_af_q;
    assign bus.push_full  = push_full_q;
    assign bus.push_error = push_err_q;
    assign bus.pop_empty  = pop_empty_q;
    assign bus.pop_ae     = pop_ae_q;
    assign bus.pop_hf     = pop_hf_q;
    assign bus.pop_af     = pop_af_q;
    assign bus.pop_full   = pop_full_q;
    assign bus.pop_error  = pop_err_q;
    assign bus.data_out   = pop_empty_q ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_ew_fifo_s1_sf.sv
// tb/tb_ew_fifo_s1_sf.sv - randomized self-checking bench for ew_fifo_s1_sf against a queue model
module tb_ew_fifo_s1_sf;
    localparam int DW  = 32;
    localparam int D   = 8;
    localparam int WRS = 2;
    localparam int RDS = 2;
    localparam int WAE = 2;
    localparam int WAF = 2;
    localparam int RAE = 3;
    localparam int RAF = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ew_fifo_s1_sf_if #(.DATA_WIDTH(DW)) bus0 ();
    ew_fifo_s1_sf_if #(.DATA_WIDTH(DW)) bus1 ();

    ew_fifo_s1_sf #(
        .DATA_WIDTH(DW), .RAM_DEPTH(D), .WR_AE_LVL(WAE), .WR_AF_LVL(WAF),
        .RD_AE_LVL(RAE), .RD_AF_LVL(RAF), .ERR_MODE(0), .WR_SYNC(WRS), .RD_SYNC(RDS)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    ew_fifo_s1_sf #(
        .DATA_WIDTH(DW), .RAM_DEPTH(D), .WR_AE_LVL(WAE), .WR_AF_LVL(WAF),
        .RD_AE_LVL(RAE), .RD_AF_LVL(RAF), .ERR_MODE(1), .WR_SYNC(WRS), .RD_SYNC(RDS)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;

    // Cumulative accepted pushes/pops after the last edge ([0]) and the three edges before it.
    int wr_h [4];
    int rd_h [4];
    logic [DW-1:0] q [$];
    bit err0_push, err0_pop, err1_push, err1_pop;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int push_cnt();
        return wr_h[0] - rd_h[WRS];
    endfunction

    function automatic int pop_cnt();
        return wr_h[RDS] - rd_h[0];
    endfunction

    function automatic logic [4:0] flags(input int c, input int ae, input int af);
        return {c == 0, c <= ae, c >= D / 2, c >= D - af, c == D};
    endfunction

    task automatic check_all();
        logic [4:0]    pf;
        logic [4:0]    of;
        logic [DW-1:0] dexp;
        pf   = flags(push_cnt(), WAE, WAF);
        of   = flags(pop_cnt(), RAE, RAF);
        dexp = (pop_cnt() > 0) ? q[0] : '0;
        check("push_flags0", DW'({bus0.push_empty, bus0.push_ae, bus0.push_hf, bus0.push_af, bus0.push_full}), DW'(pf));
        check("pop_flags0",  DW'({bus0.pop_empty, bus0.pop_ae, bus0.pop_hf, bus0.pop_af, bus0.pop_full}), DW'(of));
        check("push_flags1", DW'({bus1.push_empty, bus1.push_ae, bus1.push_hf, bus1.push_af, bus1.push_full}), DW'(pf));
        check("pop_flags1",  DW'({bus1.pop_empty, bus1.pop_ae, bus1.pop_hf, bus1.pop_af, bus1.pop_full}), DW'(of));
        check("data_out0",   bus0.data_out, dexp);
        check("data_out1",   bus1.data_out, dexp);
        check("push_err_sticky", DW'(bus0.push_error), DW'(err0_push));
        check("pop_err_sticky",  DW'(bus0.pop_error),  DW'(err0_pop));
        check("push_err_pulse",  DW'(bus1.push_error), DW'(err1_push));
        check("pop_err_pulse",   DW'(bus1.pop_error),  DW'(err1_pop));
    endtask

    task automatic cycle(input bit do_rst, input bit do_push, input bit do_pop, input logic [DW-1:0] d);
        bit full_now;
        bit empty_now;
        rst             = do_rst;
        bus0.push_req_n = !do_push;
        bus1.push_req_n = !do_push;
        bus0.pop_req_n  = !do_pop;
        bus1.pop_req_n  = !do_pop;
        bus0.data_in    = d;
        bus1.data_in    = d;
        @(posedge clk);
        full_now  = (push_cnt() == D);
        empty_now = (pop_cnt() == 0);
        for (int i = 3; i > 0; i--) begin
            wr_h[i] = wr_h[i-1];
            rd_h[i] = rd_h[i-1];
        end
        if (do_rst) begin
            for (int i = 0; i < 4; i++) begin
                wr_h[i] = 0;
                rd_h[i] = 0;
            end
            q.delete();
            err0_push = 0;
            err0_pop  = 0;
            err1_push = 0;
            err1_pop  = 0;
        end else begin
            if (do_push && !full_now) begin
                q.push_back(d);
                wr_h[0]++;
            end
            if (do_pop && !empty_now) begin
                void'(q.pop_front());
                rd_h[0]++;
            end
            err0_push = err0_push | (do_push && full_now);
            err0_pop  = err0_pop  | (do_pop && empty_now);
            err1_push = do_push && full_now;
            err1_pop  = do_pop && empty_now;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int pushed;
        int popped;
        int n;
        bit dp;
        bit dq;

        for (int i = 0; i < 4; i++) begin
            wr_h[i] = 0;
            rd_h[i] = 0;
        end
        err0_push = 0;
        err0_pop  = 0;
        err1_push = 0;
        err1_pop  = 0;
        rst = 1'b1;
        bus0.push_req_n = 1'b1;
        bus1.push_req_n = 1'b1;
        bus0.pop_req_n  = 1'b1;
        bus1.pop_req_n  = 1'b1;
        bus0.data_in    = '0;
        bus1.data_in    = '0;

        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        idle(3);

        cycle(1'b0, 1'b1, 1'b0, 32'hA5A5_0001);
        idle(3);
        cycle(1'b0, 1'b0, 1'b1, '0);
        idle(3);

        // Fill past capacity: the ninth push overflows and must leave contents intact.
        for (int i = 0; i < D + 1; i++) cycle(1'b0, 1'b1, 1'b0, 32'hC0DE_0000 + DW'(i));
        idle(3);
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        idle(3);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        idle(2);

        cycle(1'b1, 1'b0, 1'b0, '0);
        pushed = 0;
        popped = 0;
        n      = 0;
        while ((pushed < 4 * D || popped < 4 * D) && n < 2000) begin
            dp = (pushed < 4 * D) && ($urandom_range(0, 2) != 0) && (push_cnt() != D);
            dq = ($urandom_range(0, 2) != 0) && (pop_cnt() != 0);
            cycle(1'b0, dp, dq, $urandom);
            pushed += int'(dp);
            popped += int'(dq);
            n++;
        end
        check("stream_within_budget", DW'(n < 2000), DW'(1));
        idle(3);

        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, $urandom);
        idle(2);
        cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0BAD_0000 + DW'(i));
        idle(3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
